// File: rtl/police_sprite_fetch_pkg.sv
// Purpose : shared sprite geometry, screen limits and the sprite pixel image
// Latency : n/a (constants, types and a pure function)
// Backpressure: n/a
package police_sprite_fetch_pkg;

  localparam int DEF_SPR_W     = 32;
  localparam int DEF_SPR_H     = 32;
  localparam int DEF_N_FRAMES  = 4;
  localparam int DEF_FRAME_DIV = 8;

  // Index 0 maps to the magenta colour key in palette_police.
  localparam logic [7:0] TRANSPARENT_IDX = 8'h00;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [9:0] coord_t;

  // Sprite image contents. The bottom row is fully transparent; every other
  // pixel is non-zero, with the animation frame in the top two bits and a
  // column/row pattern below, so frame, row and column are all visible in
  // the index value.
  function automatic logic [7:0] sprite_pixel(input int unsigned frame,
                                              input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned last_row);
    if (row == last_row) return TRANSPARENT_IDX;
    return 8'((frame * 64) + (((col ^ row) & 31) * 2) + 1);
  endfunction

endpackage

// File: rtl/police_sprite_fetch_rom.sv
// Purpose : police sprite image ROM, one 8-bit palette index per address
// Latency : 1 cycle (synchronous read)
// Backpressure: none, a read every cycle
//
// Ports:
//   i_clk   pixel clock
//   i_addr  {frame, row, col} address
//   o_data  palette index, valid the cycle after i_addr
module police_sprite_fetch_rom
  import police_sprite_fetch_pkg::*;
#(
  parameter int SPR_W    = DEF_SPR_W,
  parameter int SPR_H    = DEF_SPR_H,
  parameter int N_FRAMES = DEF_N_FRAMES,
  localparam int XW      = $clog2(SPR_W),
  localparam int YW      = $clog2(SPR_H),
  localparam int FW      = $clog2(N_FRAMES),
  localparam int AW      = FW + YW + XW
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  output logic [7:0]    o_data
);

  logic [7:0] r_data;

  // No reset: downstream masks the data with a reset hit flag.
  always_ff @(posedge i_clk) begin
    r_data <= sprite_pixel(32'(i_addr[AW-1 -: FW]),
                           32'(i_addr[XW +: YW]),
                           32'(i_addr[XW-1:0]),
                           32'(SPR_H - 1));
  end

  assign o_data = r_data;

endmodule

// File: rtl/police_sprite_fetch.sv
// Purpose : raster coords -> police sprite palette index, with walk animation
// Latency : 2 cycles from i_draw_x/i_draw_y/i_pix_valid to outputs
// Backpressure: none, fully pipelined at one pixel per clock
//
// Optional feature: define POLICE_MIRROR_EN to flip the sprite horizontally
// while i_facing_left (as latched at frame start) is set.
//
// Ports:
//   i_clk, i_rst_n        pixel clock, async active-low reset
//   i_frame_start         1-cycle pulse at start of vertical blank
//   i_pos_x, i_pos_y      sprite top-left corner (latched at frame start)
//   i_moving              walking, advances animation at frame start
//   i_facing_left         direction, used only with POLICE_MIRROR_EN
//   i_draw_x, i_draw_y    current raster position
//   i_pix_valid           raster position is in active video
//   o_index               palette index (0 = transparent)
//   o_index_valid         i_pix_valid delayed by 2 cycles
//   o_is_police           sprite covers the pixel and index is non-zero
module police_sprite_fetch
  import police_sprite_fetch_pkg::*;
#(
  parameter int SPR_W     = DEF_SPR_W,
  parameter int SPR_H     = DEF_SPR_H,
  parameter int N_FRAMES  = DEF_N_FRAMES,
  parameter int FRAME_DIV = DEF_FRAME_DIV
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_start,
  input  logic [9:0] i_pos_x,
  input  logic [9:0] i_pos_y,
  input  logic       i_moving,
  input  logic       i_facing_left,
  input  logic [9:0] i_draw_x,
  input  logic [9:0] i_draw_y,
  input  logic       i_pix_valid,
  output logic [7:0] o_index,
  output logic       o_index_valid,
  output logic       o_is_police
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int FW = $clog2(N_FRAMES);
  localparam int AW = FW + YW + XW;
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  // Frame-stable copies of the sprite position so a mid-frame update
  // cannot tear the sprite.
  coord_t r_pos_x;
  coord_t r_pos_y;

  logic [FW-1:0] r_anim_frame;
  logic [DW-1:0] r_div_cnt;

  logic [10:0]   w_dx;
  logic [10:0]   w_dy;
  logic          w_hit;
  logic [XW-1:0] w_col;
  logic [AW-1:0] w_addr;

  logic          r_hit1;
  logic          r_vld1;
  logic [AW-1:0] r_addr1;
  logic          r_hit2;
  logic          r_vld2;
  logic [7:0]    w_rom_data;

`ifdef POLICE_MIRROR_EN
  logic r_facing_left;
`else
  logic w_unused_facing;
  assign w_unused_facing = i_facing_left;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos_x <= '0;
      r_pos_y <= '0;
`ifdef POLICE_MIRROR_EN
      r_facing_left <= 1'b0;
`endif
    end else if (i_frame_start) begin
      r_pos_x <= i_pos_x;
      r_pos_y <= i_pos_y;
`ifdef POLICE_MIRROR_EN
      r_facing_left <= i_facing_left;
`endif
    end
  end

  // Animation steps once every FRAME_DIV video frames while walking;
  // i_moving only matters at frame start, so it needs no shadow copy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt    <= '0;
      r_anim_frame <= '0;
    end else if (i_frame_start) begin
      if (i_moving) begin
        if (r_div_cnt == DW'(FRAME_DIV - 1)) begin
          r_div_cnt    <= '0;
          r_anim_frame <= r_anim_frame + FW'(1);
        end else begin
          r_div_cnt <= r_div_cnt + DW'(1);
        end
      end else begin
        r_div_cnt    <= '0;
        r_anim_frame <= '0;
      end
    end
  end

  // 11-bit differences: bit 10 set means the raster is left of / above the
  // sprite, so it fails the range test instead of wrapping.
  assign w_dx  = {1'b0, i_draw_x} - {1'b0, r_pos_x};
  assign w_dy  = {1'b0, i_draw_y} - {1'b0, r_pos_y};
  assign w_hit = i_pix_valid & (w_dx[10:XW] == '0) & (w_dy[10:YW] == '0);

`ifdef POLICE_MIRROR_EN
  // For a power-of-two width, bit inversion equals SPR_W-1-dx.
  assign w_col = r_facing_left ? ~w_dx[XW-1:0] : w_dx[XW-1:0];
`else
  assign w_col = w_dx[XW-1:0];
`endif

  assign w_addr = {r_anim_frame, w_dy[YW-1:0], w_col};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit1  <= 1'b0;
      r_vld1  <= 1'b0;
      r_addr1 <= '0;
      r_hit2  <= 1'b0;
      r_vld2  <= 1'b0;
    end else begin
      r_hit1  <= w_hit;
      r_vld1  <= i_pix_valid;
      r_addr1 <= w_addr;
      r_hit2  <= r_hit1;
      r_vld2  <= r_vld1;
    end
  end

  police_sprite_fetch_rom #(
    .SPR_W    (SPR_W),
    .SPR_H    (SPR_H),
    .N_FRAMES (N_FRAMES)
  ) u_rom (
    .i_clk  (i_clk),
    .i_addr (r_addr1),
    .o_data (w_rom_data)
  );

  // r_hit2 is reset, so the outputs clear immediately on reset even though
  // the ROM data register is not.
  assign o_index       = r_hit2 ? w_rom_data : TRANSPARENT_IDX;
  assign o_is_police   = r_hit2 & (w_rom_data != TRANSPARENT_IDX);
  assign o_index_valid = r_vld2;

endmodule

// File: tb/tb_police_sprite_fetch.sv
module tb_police_sprite_fetch;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int NF   = 4;
  localparam int FDIV = 8;

  typedef struct {
    logic [7:0] idx;
    logic       vld;
    logic       pol;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       i_frame_start;
  logic [9:0] i_pos_x;
  logic [9:0] i_pos_y;
  logic       i_moving;
  logic       i_facing_left;
  logic [9:0] i_draw_x;
  logic [9:0] i_draw_y;
  logic       i_pix_valid;
  logic [7:0] o_index;
  logic       o_index_valid;
  logic       o_is_police;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t sb[$];

  // reference model state
  int m_px, m_py, m_anim, m_div;
  bit m_face;

  police_sprite_fetch dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame_start (i_frame_start),
    .i_pos_x       (i_pos_x),
    .i_pos_y       (i_pos_y),
    .i_moving      (i_moving),
    .i_facing_left (i_facing_left),
    .i_draw_x      (i_draw_x),
    .i_draw_y      (i_draw_y),
    .i_pix_valid   (i_pix_valid),
    .o_index       (o_index),
    .o_index_valid (o_index_valid),
    .o_is_police   (o_is_police)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected sprite image: bottom row transparent, otherwise
  // frame*64 + ((col^row)&31)*2 + 1.
  function automatic logic [7:0] rom_ref(input int f, input int r, input int c);
    if (r == H - 1) return 8'h00;
    return 8'((f * 64) + (((c ^ r) & 31) * 2) + 1);
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_px = 0; m_py = 0; m_anim = 0; m_div = 0; m_face = 0;
    sb.delete();
  endtask

  // One pixel clock: drive inputs, predict this pixel, clock, update the
  // frame-start state, then check the pixel driven two cycles earlier.
  task automatic cyc(input bit fs, input bit pv, input int x, input int y);
    exp_t e;
    int dx, dy, col;
    bit hit;
    logic [7:0] d;
    i_frame_start = fs;
    i_pix_valid   = pv;
    i_draw_x      = 10'(x);
    i_draw_y      = 10'(y);
    dx  = x - m_px;
    dy  = y - m_py;
    hit = pv && dx >= 0 && dx < W && dy >= 0 && dy < H;
    col = dx;
`ifdef POLICE_MIRROR_EN
    if (m_face) col = W - 1 - dx;
`endif
    d = hit ? rom_ref(m_anim, dy, col) : 8'h00;
    e.idx = d;
    e.vld = pv;
    e.pol = hit && (d != 8'h00);
    sb.push_back(e);
    @(posedge clk);
    if (fs) begin
      m_px   = int'(i_pos_x);
      m_py   = int'(i_pos_y);
      m_face = i_facing_left;
      if (i_moving) begin
        if (m_div == FDIV - 1) begin
          m_div  = 0;
          m_anim = (m_anim + 1) % NF;
        end else begin
          m_div = m_div + 1;
        end
      end else begin
        m_div  = 0;
        m_anim = 0;
      end
    end
    #1;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      chk("index", o_index, e.idx);
      chk("index_valid", {7'd0, o_index_valid}, {7'd0, e.vld});
      chk("is_police", {7'd0, o_is_police}, {7'd0, e.pol});
    end
  endtask

  task automatic set_pos(input int x, input int y);
    i_pos_x = 10'(x);
    i_pos_y = 10'(y);
  endtask

  initial begin
    rst_n = 1'b0;
    i_frame_start = 0; i_pix_valid = 0; i_moving = 0; i_facing_left = 0;
    i_draw_x = 0; i_draw_y = 0; i_pos_x = 0; i_pos_y = 0;
    model_reset();

    // reset state
    #3;
    chk("rst_index", o_index, 8'h00);
    chk("rst_valid", {7'd0, o_index_valid}, 8'h00);
    chk("rst_police", {7'd0, o_is_police}, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // basic hit / miss around (100,50)
    set_pos(100, 50);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 100, 50);   // ROM[0]
    cyc(0, 1, 99, 50);    // left of sprite
    cyc(0, 1, 131, 50);   // last column
    cyc(0, 1, 132, 50);   // right of sprite
    cyc(0, 1, 100, 81);   // bottom row, transparent
    cyc(0, 1, 100, 49);   // above sprite
    cyc(0, 0, 100, 50);   // blanking
    cyc(0, 1, 110, 60);

    // right screen edge, no wrap
    set_pos(630, 100);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 639, 100);
    cyc(0, 1, 0, 100);
    cyc(0, 1, 635, 120);

    // animation: 8 frame starts per step, wraps after 4 steps
    set_pos(100, 50);
    i_moving = 1;
    for (int s = 0; s < 5; s++) begin
      repeat (FDIV) cyc(1, 0, 0, 0);
      cyc(0, 1, 100, 50);
      cyc(0, 1, 103, 52);
    end
    cyc(1, 0, 0, 0);        // part-way through a step
    cyc(0, 1, 100, 50);
    i_moving = 0;
    cyc(1, 0, 0, 0);        // stopping resets the animation
    cyc(0, 1, 100, 50);

    // mid-frame position change is ignored until frame start
    set_pos(200, 50);
    cyc(0, 1, 100, 50);
    cyc(0, 1, 200, 50);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 200, 50);
    cyc(0, 1, 100, 50);

    // frame start coincident with a valid pixel uses the old position
    set_pos(300, 50);
    cyc(1, 1, 200, 50);
    cyc(0, 1, 300, 50);
    cyc(0, 1, 200, 50);

    // facing left: mirrored only when the mirror feature is built in
    i_facing_left = 1;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 300, 51);
    cyc(0, 1, 331, 51);
    i_facing_left = 0;

    // async reset mid-frame with a non-zero animation frame
    set_pos(100, 50);
    i_moving = 1;
    repeat (FDIV) cyc(1, 0, 0, 0);
    cyc(0, 1, 100, 50);
    cyc(0, 1, 101, 50);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_index", o_index, 8'h00);
    chk("arst_valid", {7'd0, o_index_valid}, 8'h00);
    chk("arst_police", {7'd0, o_is_police}, 8'h00);
    i_moving = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    // shadow position and animation are back at zero
    cyc(0, 1, 0, 0);
    cyc(0, 1, 5, 3);
    cyc(0, 1, 40, 3);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
